// File: rtl/stb_seq.sv
// Strobe request sequencer: issues bursts of stb_req with gap, latency stats and timeout.
// Optional running max latency via `STB_SEQ_LAT_STATS_EN.
module stb_seq #(
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   start_i,
  input  logic [BURST_WIDTH-1:0] burst_len_i,
  input  logic [CNT_WIDTH-1:0]   gap_i,
  input  logic [CNT_WIDTH-1:0]   timeout_i,
  input  logic                   rdy_i,
  input  logic                   stb_valid_i,
  input  logic [CNT_WIDTH-1:0]   stb_period_i,
  output logic                   stb_req_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [BURST_WIDTH-1:0] req_cnt_o,
  output logic [CNT_WIDTH-1:0]   last_lat_o,
  output logic [CNT_WIDTH-1:0]   max_lat_o,
  output logic [CNT_WIDTH-1:0]   period_o
);

  localparam logic [CNT_WIDTH-1:0]   C_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   C_TWO = CNT_WIDTH'(2);
  localparam logic [BURST_WIDTH-1:0] B_ONE = BURST_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    REQ,
    WAIT_ACK,
    WAIT_DONE,
    GAP,
    FINISH
  } state_t;

  state_t                 state;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [CNT_WIDTH-1:0]   gap_q;
  logic [CNT_WIDTH-1:0]   tmo_q;
  logic [CNT_WIDTH-1:0]   tmo_cnt;
  logic [CNT_WIDTH-1:0]   lat_cnt;
  logic [CNT_WIDTH-1:0]   gap_cnt;

  logic                   tmo_hit;
  logic [CNT_WIDTH-1:0]   lat_inc;
  logic [BURST_WIDTH-1:0] cnt_inc;

  assign tmo_hit = (tmo_q != '0) && (tmo_cnt == tmo_q);
  assign lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + C_ONE;
  assign cnt_inc = req_cnt_o + B_ONE;

`ifndef STB_SEQ_LAT_STATS_EN
  assign max_lat_o = '0;
`endif

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state      <= IDLE;
      burst_q    <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      tmo_cnt    <= '0;
      lat_cnt    <= '0;
      gap_cnt    <= '0;
      stb_req_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      req_cnt_o  <= '0;
      last_lat_o <= '0;
      period_o   <= '0;
`ifdef STB_SEQ_LAT_STATS_EN
      max_lat_o  <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            burst_q   <= burst_len_i;
            gap_q     <= (gap_i < C_TWO) ? C_TWO : gap_i;
            tmo_q     <= timeout_i;
            tmo_cnt   <= C_ONE;
            err_o     <= 1'b0;
            req_cnt_o <= '0;
            busy_o    <= 1'b1;
`ifdef STB_SEQ_LAT_STATS_EN
            max_lat_o <= '0;
`endif
            state <= (burst_len_i == '0) ? FINISH : WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (rdy_i) begin
            period_o <= stb_period_i;
            state    <= REQ;
          end else if (tmo_hit) begin
            err_o <= 1'b1;
            state <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + C_ONE;
          end
        end
        REQ: begin
          stb_req_o <= 1'b1;
          lat_cnt   <= C_ONE;
          tmo_cnt   <= C_ONE;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          lat_cnt <= lat_inc;
          if (!stb_valid_i) begin
            tmo_cnt <= C_ONE;
            state   <= WAIT_DONE;
          end else if (tmo_hit) begin
            stb_req_o <= 1'b0;
            err_o     <= 1'b1;
            state     <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + C_ONE;
          end
        end
        WAIT_DONE: begin
          if (stb_valid_i) begin
            // lat_cnt already counts this sampling cycle
            last_lat_o <= lat_cnt;
`ifdef STB_SEQ_LAT_STATS_EN
            if (lat_cnt > max_lat_o) max_lat_o <= lat_cnt;
`endif
            req_cnt_o <= cnt_inc;
            stb_req_o <= 1'b0;
            gap_cnt   <= C_ONE;
            state     <= (cnt_inc == burst_q) ? FINISH : GAP;
          end else if (tmo_hit) begin
            stb_req_o <= 1'b0;
            err_o     <= 1'b1;
            state     <= FINISH;
          end else begin
            lat_cnt <= lat_inc;
            tmo_cnt <= tmo_cnt + C_ONE;
          end
        end
        GAP: begin
          // The REQ cycle supplies the last low cycle of the gap
          if (gap_cnt >= gap_q - C_ONE) state <= REQ;
          else gap_cnt <= gap_cnt + C_ONE;
        end
        FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stb_seq.sv
// Directed self-checking bench for stb_seq.
// Expected values are hand-derived from the handshake timing.
module tb_stb_seq;

  localparam int CW = 32;
  localparam int BW = 16;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [BW-1:0] burst_len_i = '0;
  logic [CW-1:0] gap_i = '0;
  logic [CW-1:0] timeout_i = '0;
  logic          rdy_i = 1'b0;
  logic          stb_valid_i = 1'b1;
  logic [CW-1:0] stb_period_i = '0;
  logic          stb_req_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [BW-1:0] req_cnt_o;
  logic [CW-1:0] last_lat_o;
  logic [CW-1:0] max_lat_o;
  logic [CW-1:0] period_o;

  int errors = 0;
  int checks = 0;
  int lows;
  int his;
  logic [31:0] exp_max;

  stb_seq #(.CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .start_i      (start_i),
    .burst_len_i  (burst_len_i),
    .gap_i        (gap_i),
    .timeout_i    (timeout_i),
    .rdy_i        (rdy_i),
    .stb_valid_i  (stb_valid_i),
    .stb_period_i (stb_period_i),
    .stb_req_o    (stb_req_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .req_cnt_o    (req_cnt_o),
    .last_lat_o   (last_lat_o),
    .max_lat_o    (max_lat_o),
    .period_o     (period_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Count low cycles of stb_req_o, starting with the current one
  task automatic wait_rise(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (stb_req_o) begin
        found = 1'b1;
        break;
      end
      n++;
      tick();
    end
    if (!found) chk("rise_timeout", 0, 1);
  endtask

  // Generator response: valid low one cycle after req rises, high d cycles later
  task automatic serve(input int d, input int cnt);
    tick();
    stb_valid_i = 1'b0;
    repeat (d) tick();
    stb_valid_i = 1'b1;
    tick();
    chk("serve_req_low", stb_req_o, 0);
    chk("serve_lat", last_lat_o, d + 2);
    chk("serve_cnt", req_cnt_o, cnt);
  endtask

  initial begin
    #100 #2;
    chk("rst_req", stb_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", req_cnt_o, 0);
    chk("rst_lat", last_lat_o, 0);
    chk("rst_max", max_lat_o, 0);
    chk("rst_period", period_o, 0);
    arst_i = 1'b1;
    tick();

    // Single request, latency 12
    rdy_i = 1'b1;
    stb_period_i = 40;
    burst_len_i = 1;
    gap_i = 0;
    timeout_i = 0;
    pulse_start();
    chk("s1_busy_c1", busy_o, 1);
    chk("s1_req_c1", stb_req_o, 0);
    tick();
    chk("s1_req_c2", stb_req_o, 0);
    tick();
    chk("s1_req_c3", stb_req_o, 1);
    chk("s1_period", period_o, 40);
    serve(10, 1);
    chk("s1_busy", busy_o, 1);
    chk("s1_done_early", done_o, 0);
    tick();
    chk("s1_done", done_o, 1);
    chk("s1_busy_fall", busy_o, 0);
    chk("s1_err", err_o, 0);
`ifdef STB_SEQ_LAT_STATS_EN
    exp_max = 12;
`else
    exp_max = 0;
`endif
    chk("s1_max", max_lat_o, exp_max);
    tick();
    chk("s1_done_one", done_o, 0);

    // Burst of 3 with gap 5, distinct latencies 8, 15, 11
    burst_len_i = 3;
    gap_i = 5;
    pulse_start();
    wait_rise(lows);
    serve(6, 1);
    wait_rise(lows);
    chk("b_gap1", lows, 5);
    serve(13, 2);
    wait_rise(lows);
    chk("b_gap2", lows, 5);
    serve(9, 3);
    tick();
    chk("b_done", done_o, 1);
`ifdef STB_SEQ_LAT_STATS_EN
    exp_max = 15;
`else
    exp_max = 0;
`endif
    chk("b_max", max_lat_o, exp_max);
    tick();

    // Gap floor
    burst_len_i = 2;
    gap_i = 0;
    pulse_start();
    wait_rise(lows);
    serve(3, 1);
    wait_rise(lows);
    chk("g_floor", lows, 2);
    serve(4, 2);
    tick();
    chk("g_done", done_o, 1);
    tick();

    // Timeout in WAIT_ACK with valid stuck high
    burst_len_i = 2;
    timeout_i = 20;
    stb_valid_i = 1'b1;
    pulse_start();
    wait_rise(lows);
    chk("t_start_lat", lows, 2);
    his = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stb_req_o) break;
      his++;
      tick();
    end
    chk("t_hi_cycles", his, 20);
    chk("t_err", err_o, 1);
    chk("t_cnt", req_cnt_o, 0);
    chk("t_done_early", done_o, 0);
    tick();
    chk("t_done", done_o, 1);
    chk("t_busy", busy_o, 0);
    tick();
    timeout_i = 0;
    burst_len_i = 1;
    pulse_start();
    chk("t_err_clr", err_o, 0);
    wait_rise(lows);
    serve(2, 1);
    tick();
    chk("t2_done", done_o, 1);
    tick();

    // Not ready, no timeout: hold in WAIT_RDY
    rdy_i = 1'b0;
    stb_period_i = 123;
    pulse_start();
    repeat (50) tick();
    chk("nr_busy", busy_o, 1);
    chk("nr_req", stb_req_o, 0);
    chk("nr_period_old", period_o, 40);
    rdy_i = 1'b1;
    tick();
    chk("nr_period", period_o, 123);
    wait_rise(lows);
    serve(1, 1);
    tick();
    chk("nr_done", done_o, 1);
    tick();

    // Zero-length burst
    burst_len_i = 0;
    pulse_start();
    chk("z_done_c1", done_o, 0);
    chk("z_busy_c1", busy_o, 1);
    chk("z_req_c1", stb_req_o, 0);
    tick();
    chk("z_done_c2", done_o, 1);
    chk("z_busy_c2", busy_o, 0);
    chk("z_req_c2", stb_req_o, 0);
    chk("z_cnt", req_cnt_o, 0);
    tick();

    // Reset during WAIT_DONE
    burst_len_i = 2;
    pulse_start();
    wait_rise(lows);
    tick();
    stb_valid_i = 1'b0;
    tick();
    tick();
    chk("r_req_pre", stb_req_o, 1);
    #2 arst_i = 1'b0;
    #1;
    chk("r_req", stb_req_o, 0);
    chk("r_busy", busy_o, 0);
    chk("r_lat", last_lat_o, 0);
    chk("r_period", period_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r_no_done", done_o, 0);
    end
    stb_valid_i = 1'b1;
    arst_i = 1'b1;
    tick();
    burst_len_i = 1;
    pulse_start();
    wait_rise(lows);
    chk("r2_start_lat", lows, 2);
    serve(5, 1);
    tick();
    chk("r2_done", done_o, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
